// File: rtl/dm_cache_ctrl.sv
// Direct-mapped cache controller: hit check, dirty-line writeback, 4-word line fill
// through a fixed-latency memory, then a replay of the original CPU access.
module dm_cache_ctrl #(
  parameter int MEM_LAT = 2,
  parameter int TAG_W   = 5,
  parameter int IDX_W   = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cpu_rd,
  input  logic             i_cpu_wr,
  input  logic [15:0]      i_cpu_addr,
  input  logic [15:0]      i_cpu_data_in,
  output logic [15:0]      o_cpu_data_out,
  output logic             o_done,
  output logic             o_stall,
  output logic             o_cache_hit,
  output logic             o_err,
  output logic             o_c_enable,
  output logic             o_c_comp,
  output logic             o_c_write,
  output logic             o_c_valid_in,
  output logic [TAG_W-1:0] o_c_tag,
  output logic [IDX_W-1:0] o_c_index,
  output logic [2:0]       o_c_offset,
  output logic [15:0]      o_c_data_in,
  input  logic             i_c_hit,
  input  logic             i_c_dirty,
  input  logic             i_c_valid,
  input  logic [TAG_W-1:0] i_c_tag_out,
  input  logic [15:0]      i_c_data_out,
  output logic             o_mem_rd,
  output logic             o_mem_wr,
  output logic [15:0]      o_mem_addr,
  output logic [15:0]      o_mem_data_in,
  input  logic [15:0]      i_mem_data_out,
  input  logic             i_mem_stall
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_WB0   = 4'd1;
  localparam logic [3:0] S_WB1   = 4'd2;
  localparam logic [3:0] S_WB2   = 4'd3;
  localparam logic [3:0] S_WB3   = 4'd4;
  localparam logic [3:0] S_RD0   = 4'd5;
  localparam logic [3:0] S_RD1   = 4'd6;
  localparam logic [3:0] S_RD2   = 4'd7;
  localparam logic [3:0] S_RD3   = 4'd8;
  localparam logic [3:0] S_FILL0 = 4'd9;
  localparam logic [3:0] S_FILL1 = 4'd10;
  localparam logic [3:0] S_FINAL = 4'd11;

  logic [3:0]       r_state;
  logic [3:0]       w_state_next;
  logic [TAG_W-1:0] r_tag;
  logic [IDX_W-1:0] r_index;
  logic [2:0]       r_offset;
  logic [15:0]      r_data;
  logic             r_wr;
  logic [MEM_LAT-1:0] r_pipe_v;
  logic [1:0]       r_pipe_w [MEM_LAT];

  logic       w_req;
  logic       w_latch;
  logic       w_is_rd;
  logic       w_push;
  logic       w_fill;
  logic       w_pipe_busy;
  logic [1:0] w_word;

  // WB0..WB3 and RD0..RD3 are consecutive codes, so the word number is the low bits minus one.
  assign w_word      = r_state[1:0] - 2'd1;
  assign w_req       = i_cpu_rd ^ i_cpu_wr;
  assign w_is_rd     = (r_state >= S_RD0) && (r_state <= S_RD3);
  assign w_push      = w_is_rd && !i_mem_stall;
  assign w_fill      = r_pipe_v[MEM_LAT-1];
  assign w_pipe_busy = |r_pipe_v[MEM_LAT-2:0];

  always_comb begin
    o_cpu_data_out = '0;
    o_done         = 1'b0;
    o_stall        = 1'b0;
    o_cache_hit    = 1'b0;
    o_err          = 1'b0;
    o_c_enable     = 1'b0;
    o_c_comp       = 1'b0;
    o_c_write      = 1'b0;
    o_c_valid_in   = 1'b0;
    o_c_tag        = '0;
    o_c_index      = '0;
    o_c_offset     = '0;
    o_c_data_in    = '0;
    o_mem_rd       = 1'b0;
    o_mem_wr       = 1'b0;
    o_mem_addr     = '0;
    o_mem_data_in  = '0;
    w_state_next   = r_state;
    w_latch        = 1'b0;
    if (!i_rst) begin
      case (r_state)
        S_IDLE: begin
          if (i_cpu_rd && i_cpu_wr) begin
            o_err = 1'b1;
          end else if (w_req) begin
            o_c_enable  = 1'b1;
            o_c_comp    = 1'b1;
            o_c_write   = i_cpu_wr;
            o_c_tag     = i_cpu_addr[15:16-TAG_W];
            o_c_index   = i_cpu_addr[IDX_W+2:3];
            o_c_offset  = i_cpu_addr[2:0];
            o_c_data_in = i_cpu_data_in;
            if (i_c_hit && i_c_valid) begin
              o_done         = 1'b1;
              o_cache_hit    = 1'b1;
              o_cpu_data_out = i_c_data_out;
            end else begin
              o_stall      = 1'b1;
              w_latch      = 1'b1;
              w_state_next = (i_c_valid && i_c_dirty) ? S_WB0 : S_RD0;
            end
          end
        end
        S_WB0, S_WB1, S_WB2, S_WB3: begin
          o_stall       = 1'b1;
          o_c_enable    = 1'b1;
          o_c_tag       = r_tag;
          o_c_index     = r_index;
          o_c_offset    = {w_word, 1'b0};
          o_mem_wr      = 1'b1;
          o_mem_addr    = {i_c_tag_out, r_index, w_word, 1'b0};
          o_mem_data_in = i_c_data_out;
          if (!i_mem_stall) w_state_next = r_state + 4'd1;
        end
        S_RD0, S_RD1, S_RD2, S_RD3: begin
          o_stall    = 1'b1;
          o_mem_rd   = 1'b1;
          o_mem_addr = {r_tag, r_index, w_word, 1'b0};
          if (!i_mem_stall) w_state_next = r_state + 4'd1;
        end
        S_FILL0: begin
          o_stall      = 1'b1;
          w_state_next = S_FILL1;
        end
        S_FILL1: begin
          o_stall = 1'b1;
          if (!w_pipe_busy) w_state_next = S_FINAL;
        end
        S_FINAL: begin
          o_c_enable     = 1'b1;
          o_c_comp       = 1'b1;
          o_c_write      = r_wr;
          o_c_tag        = r_tag;
          o_c_index      = r_index;
          o_c_offset     = r_offset;
          o_c_data_in    = r_data;
          o_done         = 1'b1;
          o_cpu_data_out = i_c_data_out;
          w_state_next   = S_IDLE;
        end
        default: w_state_next = S_IDLE;
      endcase
      // Returning fill words take the cache port regardless of the current state.
      if (w_fill) begin
        o_c_enable   = 1'b1;
        o_c_comp     = 1'b0;
        o_c_write    = 1'b1;
        o_c_valid_in = 1'b1;
        o_c_tag      = r_tag;
        o_c_index    = r_index;
        o_c_offset   = {r_pipe_w[MEM_LAT-1], 1'b0};
        o_c_data_in  = i_mem_data_out;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_tag    <= '0;
      r_index  <= '0;
      r_offset <= '0;
      r_data   <= '0;
      r_wr     <= 1'b0;
      r_pipe_v <= '0;
      for (int k = 0; k < MEM_LAT; k++) r_pipe_w[k] <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_latch) begin
        r_tag    <= i_cpu_addr[15:16-TAG_W];
        r_index  <= i_cpu_addr[IDX_W+2:3];
        r_offset <= i_cpu_addr[2:0];
        r_data   <= i_cpu_data_in;
        r_wr     <= i_cpu_wr;
      end
      r_pipe_v[0] <= w_push;
      r_pipe_w[0] <= w_word;
      for (int k = MEM_LAT-1; k > 0; k--) begin
        r_pipe_v[k] <= r_pipe_v[k-1];
        r_pipe_w[k] <= r_pipe_w[k-1];
      end
    end
  end

endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
- Controller FSM for the direct-mapped cache. It sits between the CPU memory-stage request and the cache array plus the four-bank main memory.
- It sequences hit checks, dirty-line writeback, 4-word line fill and the final replayed access.
- Next-state and outputs feed the state register, which is built from the enabled dff cells.
- Line geometry: 8 bytes, 4 words of 16 bits. Address fields: tag[15:11], index[10:3], offset[2:0], word select = offset[2:1].

Parameters:
- MEM_LAT, 2, cycles from an accepted mem_rd to valid mem_data_out (fixed).
- TAG_W, 5, tag width.
- IDX_W, 8, index width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- cpu_rd  in  1  read request
- cpu_wr  in  1  write request
- cpu_addr  in  16  byte address (bit0 ignored)
- cpu_data_in  in  16  write data
- cpu_data_out  out  16  read data, valid when done=1
- done  out  1  one-cycle completion pulse
- stall  out  1  CPU must hold its request
- cache_hit  out  1  with done: request satisfied without memory traffic
- err  out  1  illegal request (rd and wr both high)
- c_enable, c_comp, c_write, c_valid_in  out  1 each  cache array controls
- c_tag  out  5  tag to cache
- c_index  out  8  index to cache
- c_offset  out  3  offset to cache
- c_data_in  out  16  write data to cache
- c_hit, c_dirty, c_valid  in  1 each  cache status
- c_tag_out  in  5  stored tag
- c_data_out  in  16  cache read data
- mem_rd, mem_wr  out  1 each  memory requests
- mem_addr  out  16  memory address
- mem_data_in  out  16  memory write data
- mem_data_out  in  16  memory read data
- mem_stall  in  1  memory cannot accept a request this cycle

Behaviour:
- Reset: rst high forces IDLE immediately and clears the request latch and fill pipeline. All outputs read 0 while rst is high and in IDLE with no request. Reset mid-writeback or mid-fill abandons the operation; the line is left as partially written.
- States: IDLE, WB0-WB3, RD0-RD3, FILL0, FILL1, FINAL.
- IDLE, cpu_rd xor cpu_wr:
  - Drive c_enable=1, c_comp=1, c_write=cpu_wr and the address fields combinationally.
  - If c_hit & c_valid: done=1, cache_hit=1, stall=0, cpu_data_out=c_data_out, stay IDLE. The write-hit sets dirty inside the cache.
  - Otherwise stall=1, latch addr/data/op, go to WB0 if c_valid & c_dirty, else RD0.
- IDLE, cpu_rd & cpu_wr: err=1 for that cycle, no cache or memory activity, stay IDLE.
- WBi:
  - Cache read with c_comp=0, c_offset={i,0}.
  - mem_wr=1, mem_addr={c_tag_out, latched index, i, 0}, mem_data_in=c_data_out.
  - If mem_stall: hold WBi. Else go to WB(i+1); WB3 goes to RD0.
- RDi:
  - mem_rd=1, mem_addr={latched tag, index, i, 0}.
  - If mem_stall: hold RDi, nothing enters the pipe. Else push word i into a 2-entry fill pipe (valid, word) and advance; RD3 goes to FILL0.
- Fill writes: when the pipe head is valid (MEM_LAT cycles after acceptance):
  - c_enable=1, c_comp=0, c_write=1, c_valid_in=1, c_offset={word,0}, c_data_in=mem_data_out.
  - This happens concurrently with the RD/FILL state outputs.
- FILL0 and FILL1 issue no requests; they drain the pipe. FILL1 goes to FINAL once the pipe is empty.
- FINAL:
  - Replay the latched op with c_comp=1, c_write=latched wr, c_data_in=latched data.
  - done=1, cache_hit=0, stall=0, cpu_data_out=c_data_out. Go to IDLE.
- stall=1 in every state except IDLE and FINAL, and in IDLE on a miss.
- CPU inputs are ignored outside IDLE.
- Clean miss with no mem_stall: done in cycle 7 after the request cycle (cycle 0). Dirty miss: cycle 11. Each mem_stall cycle adds 1.

Test Plan:
- Reset, then cpu_rd addr 0x0104 on a cold cache -> mem_rd addrs 0x0100, 0x0102, 0x0104, 0x0106 in cycles 1-4. Four fill writes with c_valid_in=1. done in cycle 7, cache_hit=0, cpu_data_out=mem word @0x0104.
- Repeat cpu_rd 0x0104 -> done and cache_hit=1 in the same cycle, no mem_rd/mem_wr.
- cpu_wr 0x0104 data 0xBEEF (hit), then cpu_rd 0x0904 (same index 0x20, tag 1):
  - mem_wr to 0x0100-0x0106 with the 0x0104 word =0xBEEF.
  - Then fill from 0x0900-0x0906.
  - done in cycle 11.
- mem_stall high for 3 cycles during RD1 -> RD1 held, mem_addr stable at 0x0102. Fill data lands on the correct offsets; done delayed by 3 cycles.
- rst asserted during FILL0 -> immediately IDLE, all outputs 0. A subsequent cpu_rd is serviced normally.
- cpu_rd=cpu_wr=1 in IDLE -> err=1 for one cycle, done=0, no c_enable, no memory activity.
